// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
//   NUM_REQ / IDX_W / CNT_W : requester count, index width, hold counter width
//   state_t                 : arbiter FSM encoding
//   pick_first()            : rotate-and-priority-encode of a request vector
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req when scanning start, start+1, ... (mod NUM_REQ).
  // Doubling the vector turns the rotation into a plain part-select.
  function automatic pick_t pick_first(input logic [NUM_REQ-1:0] req,
                                       input logic [IDX_W-1:0]   start);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    pick_t                res;
    dbl = {req, req};
    rot = dbl[start +: NUM_REQ];
    res = '0;
    // Descending scan so the lowest rotated position wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        res.found = 1'b1;
        res.idx   = start + IDX_W'(k);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/arb_rr4_dec2to4_en.sv
// 2-to-4 one-hot decoder with enable.
//   i_idx : binary index
//   i_en  : enable; output is 0000 when low
//   o_dec : one-hot decode of i_idx
module dec2to4_en
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   i_idx,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_dec
);

  always_comb begin
    o_dec = '0;
    if (i_en) o_dec[i_idx] = 1'b1;
  end

endmodule

// File: rtl/arb_rr4.sv
// 4-requester round-robin arbiter with bounded hold time.
//   i_clk      : system clock, rising edge
//   i_rst_n    : synchronous active-low reset
//   i_en       : arbitration enable; low blocks new grants, never revokes one
//   i_req      : request vector, bit i = requester i
//   o_gnt      : one-hot grant, 0000 when idle
//   o_gnt_idx  : index of current grantee; holds last value when idle
//   o_gnt_vld  : high while a grant is active
//
// state   | meaning
// --------+------------------------------------------
// ST_IDLE | no grant; waiting for enable and a request
// ST_BUSY | one grant active, hold counter running
module arb_rr4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_gnt_vld
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_gnt_idx;
  logic             r_gnt_vld;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;

  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_gnt_idx_nxt;
  logic             w_gnt_vld_nxt;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             w_release;
  logic [IDX_W-1:0] w_start;
  pick_t            w_pick;
  logic             w_grant;

  // While busy the search begins just after the grantee, so the grantee
  // itself is reached last and is re-picked only when nobody else waits.
  assign w_release = !i_req[r_gnt_idx] || (r_cnt == CNT_LAST);
  assign w_start   = (r_state == ST_BUSY) ? r_gnt_idx + IDX_W'(1) : r_ptr;
  assign w_pick    = pick_first(i_req, w_start);
  assign w_grant   = i_en && w_pick.found;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_gnt_idx <= '0;
      r_gnt_vld <= 1'b0;
      r_ptr     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt_idx <= w_gnt_idx_nxt;
      r_gnt_vld <= w_gnt_vld_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_release && !w_grant) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_gnt_idx_nxt = r_gnt_idx;
    w_gnt_vld_nxt = r_gnt_vld;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_gnt_idx_nxt = w_pick.idx;
          w_gnt_vld_nxt = 1'b1;
          w_cnt_nxt     = '0;
        end
      end
      ST_BUSY: begin
        if (w_release) begin
          w_ptr_nxt = r_gnt_idx + IDX_W'(1);
          w_cnt_nxt = '0;
          if (w_grant) begin
            w_gnt_idx_nxt = w_pick.idx;
            w_gnt_vld_nxt = 1'b1;
          end else begin
            w_gnt_vld_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_gnt_vld_nxt = 1'b0;
        w_cnt_nxt     = '0;
      end
    endcase
  end

  dec2to4_en u_dec (
    .i_idx (r_gnt_idx),
    .i_en  (r_gnt_vld),
    .o_dec (o_gnt)
  );

  assign o_gnt_idx = r_gnt_idx;
  assign o_gnt_vld = r_gnt_vld;

endmodule

// File: tb/tb_arb_rr4.sv
module tb_arb_rr4;
  import arb_pkg::*;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b1;
  logic [3:0] req   = 4'hF;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] idx;
    string      tag;
  } exp_t;

  exp_t sb[$];

  arb_rr4 #(.HOLD_MAX(4)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_en      (en),
    .i_req     (req),
    .o_gnt     (gnt),
    .o_gnt_idx (gnt_idx),
    .o_gnt_vld (gnt_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the output expected after the edge,
  // then pop and compare once the DUT has registered it.
  task automatic cyc(input logic rn, input logic e, input logic [3:0] rq,
                     input logic [3:0] eg, input logic [1:0] ei, input string tag);
    exp_t x;
    rst_n = rn;
    en    = e;
    req   = rq;
    x.gnt = eg;
    x.vld = (eg != 4'h0);
    x.idx = ei;
    x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " sb_empty"}, 32'(1), 32'(0));
    end else begin
      x = sb.pop_front();
      chk({x.tag, " gnt"}, 32'(gnt), 32'(x.gnt));
      chk({x.tag, " vld"}, 32'(gnt_vld), 32'(x.vld));
      chk({x.tag, " idx"}, 32'(gnt_idx), 32'(x.idx));
    end
  endtask

  initial begin
    // reset held with all requests pending
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 4'hF, 4'h0, 2'd0, "rst_hold");
    chk("rst ptr", 32'(dut.r_ptr), 32'(0));
    chk("rst cnt", 32'(dut.r_cnt), 32'(0));

    // all requesting, hold limit 4: 4 cycles each, rotating, no gaps
    for (int k = 0; k < 18; k++) begin
      int g;
      g = (k / 4) % 4;
      cyc(1'b1, 1'b1, 4'hF, 4'(1 << g), 2'(g), "rr_hold4");
    end

    cyc(1'b0, 1'b1, 4'h0, 4'h0, 2'd0, "rst2");

    // lone requester re-granted on every timeout without a gap
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, 1'b1, 4'h1, 4'h1, 2'd0, "solo_hold");
      chk("solo cnt", 32'(dut.r_cnt), 32'(k % 4));
    end
    cyc(1'b1, 1'b1, 4'h0, 4'h0, 2'd0, "solo_drop");
    chk("solo ptr", 32'(dut.r_ptr), 32'(1));

    // requester 2 for three cycles, then drop: grant gone next cycle
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 4'h4, 4'h4, 2'd2, "req2_hold");
    cyc(1'b1, 1'b1, 4'h0, 4'h0, 2'd2, "req2_drop");
    chk("req2 ptr", 32'(dut.r_ptr), 32'(3));

    // search from PTR=3, same-cycle handoff, wrap to index 0
    cyc(1'b1, 1'b1, 4'h2, 4'h2, 2'd1, "pick_from_ptr3");
    cyc(1'b1, 1'b1, 4'h4, 4'h4, 2'd2, "same_cycle_handoff");
    cyc(1'b1, 1'b1, 4'h5, 4'h4, 2'd2, "hold_while_req");
    cyc(1'b1, 1'b1, 4'h1, 4'h1, 2'd0, "handoff_wrap");
    cyc(1'b1, 1'b1, 4'h0, 4'h0, 2'd0, "drop_idle");

    // enable low in idle blocks grants
    cyc(1'b1, 1'b0, 4'hF, 4'h0, 2'd0, "en_low_idle");
    cyc(1'b1, 1'b0, 4'hF, 4'h0, 2'd0, "en_low_idle");

    cyc(1'b0, 1'b1, 4'h0, 4'h0, 2'd0, "rst3");

    // enable low keeps grant, blocks handoff at release
    cyc(1'b1, 1'b1, 4'h3, 4'h1, 2'd0, "en_grant0");
    cyc(1'b1, 1'b0, 4'h3, 4'h1, 2'd0, "en_low_keep");
    cyc(1'b1, 1'b0, 4'h3, 4'h1, 2'd0, "en_low_keep");
    cyc(1'b1, 1'b0, 4'h2, 4'h0, 2'd0, "en_low_release");
    cyc(1'b1, 1'b0, 4'h2, 4'h0, 2'd0, "en_low_blocked");
    cyc(1'b1, 1'b0, 4'h2, 4'h0, 2'd0, "en_low_blocked");
    cyc(1'b1, 1'b1, 4'h2, 4'h2, 2'd1, "en_high_grant1");

    // reset in the middle of a grant to requester 3
    cyc(1'b1, 1'b1, 4'h8, 4'h8, 2'd3, "grant3");
    cyc(1'b1, 1'b1, 4'h8, 4'h8, 2'd3, "grant3_hold");
    cyc(1'b0, 1'b1, 4'h8, 4'h0, 2'd0, "rst_midgrant");
    chk("midrst ptr", 32'(dut.r_ptr), 32'(0));
    cyc(1'b1, 1'b1, 4'h8, 4'h8, 2'd3, "regrant3");
    chk("regrant ptr", 32'(dut.r_ptr), 32'(0));
    cyc(1'b1, 1'b1, 4'h0, 4'h0, 2'd3, "drop3");
    chk("wrap ptr", 32'(dut.r_ptr), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
